// File: rtl/rw_scoreboard_regfile.sv
// Write-back stage with register file, two combinational read ports and a per-register
// busy scoreboard that decode uses to stall reads of destinations still in flight.
module rw_scoreboard_regfile #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4,
  parameter int RA_IDX   = 15,
  parameter int PC_INC   = 4,
  parameter int BYPASS   = 1
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              isWb,
  input  logic              isCall,
  input  logic              isLd,
  input  logic [ADDR_W-1:0] Rd,
  input  logic [DATA_W-1:0] aluResult,
  input  logic [DATA_W-1:0] ldResult,
  input  logic [DATA_W-1:0] pc_current,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_rd,
  input  logic [ADDR_W-1:0] reg_addr1,
  input  logic [ADDR_W-1:0] reg_addr2,
  output logic [DATA_W-1:0] reg_data1,
  output logic [DATA_W-1:0] reg_data2,
  output logic              reg_busy1,
  output logic              reg_busy2,
  output logic              hazard
);

  localparam logic [ADDR_W-1:0] LP_RA_IDX = ADDR_W'(RA_IDX);
  localparam logic [DATA_W-1:0] LP_PC_INC = DATA_W'(PC_INC);
  localparam logic              LP_BYPASS = (BYPASS != 0);

  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_busy;

  logic [ADDR_W-1:0]   w_wdst;
  logic [DATA_W-1:0]   w_ra;
  logic [DATA_W-1:0]   w_wdat;
  logic                w_wdst_ok;
  logic                w_we;
  logic [DATA_W-1:0]   w_arr1;
  logic [DATA_W-1:0]   w_arr2;
  logic                w_bsy1;
  logic                w_bsy2;
  logic                w_byp1;
  logic                w_byp2;
  logic [NUM_REGS-1:0] w_busy_nxt;

  // Write-back source select; return address wraps modulo 2**DATA_W.
  always_comb begin
    w_ra   = pc_current + LP_PC_INC;
    w_wdst = isCall ? LP_RA_IDX : Rd;
    if (isCall)
      w_wdat = w_ra;
    else if (isLd)
      w_wdat = ldResult;
    else
      w_wdat = aluResult;
  end

  // Index decode by comparison so out-of-range indices simply match nothing.
  always_comb begin
    w_wdst_ok = 1'b0;
    w_arr1    = '0;
    w_arr2    = '0;
    w_bsy1    = 1'b0;
    w_bsy2    = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_wdst == ADDR_W'(i))
        w_wdst_ok = 1'b1;
      if (reg_addr1 == ADDR_W'(i)) begin
        w_arr1 = r_regs[i];
        w_bsy1 = r_busy[i];
      end
      if (reg_addr2 == ADDR_W'(i)) begin
        w_arr2 = r_regs[i];
        w_bsy2 = r_busy[i];
      end
    end
  end

  assign w_we   = isWb & w_wdst_ok;
  assign w_byp1 = LP_BYPASS & w_we & (reg_addr1 == w_wdst);
  assign w_byp2 = LP_BYPASS & w_we & (reg_addr2 == w_wdst);

  assign reg_data1 = w_byp1 ? w_wdat : w_arr1;
  assign reg_data2 = w_byp2 ? w_wdat : w_arr2;
  assign reg_busy1 = w_bsy1 & ~w_byp1;
  assign reg_busy2 = w_bsy2 & ~w_byp2;
  assign hazard    = reg_busy1 | reg_busy2;

  // Clear is applied before set so a same-index issue keeps the register owned.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_we && (w_wdst == ADDR_W'(i)))
        w_busy_nxt[i] = 1'b0;
      if (iss_valid && (iss_rd == ADDR_W'(i)))
        w_busy_nxt[i] = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++)
        r_regs[i] <= '0;
      r_busy <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++)
        if (w_we && (w_wdst == ADDR_W'(i)))
          r_regs[i] <= w_wdat;
      r_busy <= w_busy_nxt;
    end
  end

endmodule

// File: tb/tb_rw_scoreboard_regfile.sv
// Bench for rw_scoreboard_regfile: bypassing and non-bypassing instances share stimulus
// and are compared against an array-based model of the register file and scoreboard.
module tb_rw_scoreboard_regfile;

  localparam int NR = 16;

  logic        Clk = 1'b0;
  logic        reset;
  logic        isWb, isCall, isLd;
  logic [3:0]  Rd;
  logic [31:0] aluResult, ldResult, pc_current;
  logic        iss_valid;
  logic [3:0]  iss_rd, reg_addr1, reg_addr2;

  logic [31:0] b_data1, b_data2, n_data1, n_data2;
  logic        b_busy1, b_busy2, b_hazard, n_busy1, n_busy2, n_hazard;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_regs [NR];
  logic        m_busy [NR];

  always #5 Clk = ~Clk;

  rw_scoreboard_regfile #(.BYPASS(1)) u_byp (
    .Clk(Clk), .reset(reset), .isWb(isWb), .isCall(isCall), .isLd(isLd), .Rd(Rd),
    .aluResult(aluResult), .ldResult(ldResult), .pc_current(pc_current),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .reg_addr1(reg_addr1), .reg_addr2(reg_addr2),
    .reg_data1(b_data1), .reg_data2(b_data2), .reg_busy1(b_busy1), .reg_busy2(b_busy2),
    .hazard(b_hazard)
  );

  rw_scoreboard_regfile #(.BYPASS(0)) u_nobyp (
    .Clk(Clk), .reset(reset), .isWb(isWb), .isCall(isCall), .isLd(isLd), .Rd(Rd),
    .aluResult(aluResult), .ldResult(ldResult), .pc_current(pc_current),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .reg_addr1(reg_addr1), .reg_addr2(reg_addr2),
    .reg_data1(n_data1), .reg_data2(n_data2), .reg_busy1(n_busy1), .reg_busy2(n_busy2),
    .hazard(n_hazard)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] m_dst();
    return isCall ? 4'd15 : Rd;
  endfunction

  function automatic logic [31:0] m_dat();
    if (isCall) return pc_current + 32'd4;
    if (isLd)   return ldResult;
    return aluResult;
  endfunction

  function automatic logic [31:0] m_rd(input logic [3:0] a, input bit byp);
    if (byp && isWb && (a == m_dst()) && (int'(m_dst()) < NR)) return m_dat();
    if (int'(a) < NR) return m_regs[a];
    return 32'd0;
  endfunction

  function automatic logic m_bz(input logic [3:0] a, input bit byp);
    logic b;
    b = (int'(a) < NR) ? m_busy[a] : 1'b0;
    return b && !(byp && isWb && (a == m_dst()));
  endfunction

  task automatic check_all(input string tag);
    #1;
    chk({tag, "_b_d1"}, b_data1, m_rd(reg_addr1, 1'b1));
    chk({tag, "_b_d2"}, b_data2, m_rd(reg_addr2, 1'b1));
    chk({tag, "_b_bz1"}, 32'(b_busy1), 32'(m_bz(reg_addr1, 1'b1)));
    chk({tag, "_b_bz2"}, 32'(b_busy2), 32'(m_bz(reg_addr2, 1'b1)));
    chk({tag, "_b_hz"}, 32'(b_hazard), 32'(m_bz(reg_addr1, 1'b1) | m_bz(reg_addr2, 1'b1)));
    chk({tag, "_n_d1"}, n_data1, m_rd(reg_addr1, 1'b0));
    chk({tag, "_n_d2"}, n_data2, m_rd(reg_addr2, 1'b0));
    chk({tag, "_n_bz1"}, 32'(n_busy1), 32'(m_bz(reg_addr1, 1'b0)));
    chk({tag, "_n_bz2"}, 32'(n_busy2), 32'(m_bz(reg_addr2, 1'b0)));
    chk({tag, "_n_hz"}, 32'(n_hazard), 32'(m_bz(reg_addr1, 1'b0) | m_bz(reg_addr2, 1'b0)));
  endtask

  task automatic tick();
    @(posedge Clk);
    if (reset) begin
      for (int i = 0; i < NR; i++) begin
        m_regs[i] = 32'd0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (isWb && (int'(m_dst()) < NR)) begin
        m_regs[m_dst()] = m_dat();
        m_busy[m_dst()] = 1'b0;
      end
      if (iss_valid && (int'(iss_rd) < NR)) m_busy[iss_rd] = 1'b1;
    end
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; isWb = 1'b0; isCall = 1'b0; isLd = 1'b0; Rd = 4'd0;
    aluResult = 32'd0; ldResult = 32'd0; pc_current = 32'd0;
    iss_valid = 1'b0; iss_rd = 4'd0;
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin
      m_regs[i] = 32'hxxxxxxxx;
      m_busy[i] = 1'bx;
    end
    idle();
    reg_addr1 = 4'd1; reg_addr2 = 4'd15;
    // Write and issue during reset must both be ignored.
    reset = 1'b1; isWb = 1'b1; Rd = 4'd6; aluResult = 32'hFFFF; iss_valid = 1'b1; iss_rd = 4'd9;
    tick();
    idle();
    check_all("rst");
    chk("rst_d1", b_data1, 32'd0);
    chk("rst_d2", b_data2, 32'd0);
    chk("rst_hz", 32'(b_hazard), 32'd0);
    reg_addr2 = 4'd9; #1;
    chk("rst_iss_ignored", 32'(b_busy2), 32'd0);
    reg_addr1 = 4'd6; #1;
    chk("rst_wb_ignored", b_data1, 32'd0);

    // Write-back sources
    idle(); reg_addr1 = 4'd1; reg_addr2 = 4'd2;
    isWb = 1'b1; Rd = 4'd1; aluResult = 32'hDEADBEEF; check_all("wb_alu"); tick();
    idle(); isWb = 1'b1; isLd = 1'b1; Rd = 4'd2; ldResult = 32'hBEEFCAFE; aluResult = 32'h1111;
    check_all("wb_ld"); tick();
    idle(); isWb = 1'b1; isCall = 1'b1; isLd = 1'b1; Rd = 4'd3; pc_current = 32'h00001000;
    ldResult = 32'h2222; check_all("wb_call"); tick();
    idle(); check_all("rd12");
    chk("rd1_alu", b_data1, 32'hDEADBEEF);
    chk("rd2_ld", b_data2, 32'hBEEFCAFE);
    reg_addr1 = 4'd15; reg_addr2 = 4'd3; check_all("rd15_3");
    chk("rd15_ra", b_data1, 32'h00001004);
    chk("rd3_untouched", b_data2, 32'd0);

    // Bypass versus array-only reads
    idle(); reg_addr1 = 4'd5; reg_addr2 = 4'd5; isWb = 1'b1; Rd = 4'd5; aluResult = 32'h12345678;
    check_all("byp");
    chk("byp_same_cycle", b_data1, 32'h12345678);
    chk("byp_both_ports", b_data2, 32'h12345678);
    chk("nobyp_old", n_data1, 32'd0);
    tick(); idle(); check_all("byp_next");
    chk("nobyp_next", n_data1, 32'h12345678);

    // Scoreboard set then clear by write-back
    idle(); iss_valid = 1'b1; iss_rd = 4'd7; reg_addr1 = 4'd7; reg_addr2 = 4'd0;
    check_all("iss7"); tick();
    idle(); check_all("hz7");
    chk("hz7_b", 32'(b_hazard), 32'd1);
    isWb = 1'b1; isLd = 1'b1; Rd = 4'd7; ldResult = 32'hA5A5A5A5; check_all("wb7");
    chk("wb7_b_hz", 32'(b_hazard), 32'd0);
    chk("wb7_n_hz", 32'(n_hazard), 32'd1);
    chk("wb7_b_d1", b_data1, 32'hA5A5A5A5);
    tick(); idle(); check_all("wb7_after");
    chk("wb7_after_n_hz", 32'(n_hazard), 32'd0);

    // Same-index set and clear: set wins
    idle(); iss_valid = 1'b1; iss_rd = 4'd4; isWb = 1'b1; Rd = 4'd4; aluResult = 32'h44;
    reg_addr1 = 4'd4; check_all("coll"); tick();
    idle(); check_all("coll_after");
    chk("coll_busy", 32'(b_busy1), 32'd1);
    tick();
    idle(); isWb = 1'b1; Rd = 4'd4; aluResult = 32'h55; tick();
    idle(); check_all("coll_clr");
    chk("coll_clr_busy", 32'(n_busy1), 32'd0);

    // Return-address wrap, then reset with a pending busy bit
    idle(); isWb = 1'b1; isCall = 1'b1; pc_current = 32'hFFFFFFFE; tick();
    idle(); reg_addr1 = 4'd15; check_all("wrap");
    chk("wrap_ra", b_data1, 32'h00000002);
    iss_valid = 1'b1; iss_rd = 4'd6; tick();
    idle(); reg_addr1 = 4'd6; reg_addr2 = 4'd15; check_all("busy6");
    chk("busy6_hz", 32'(b_hazard), 32'd1);
    reset = 1'b1; tick();
    idle(); check_all("rst2");
    chk("rst2_d2", b_data2, 32'd0);
    chk("rst2_hz", 32'(b_hazard), 32'd0);

    // Randomized traffic
    for (int c = 0; c < 800; c++) begin
      reset      = ($urandom_range(0, 99) == 0);
      isWb       = $urandom_range(0, 1);
      isCall     = ($urandom_range(0, 5) == 0);
      isLd       = $urandom_range(0, 1);
      Rd         = 4'($urandom_range(0, 15));
      aluResult  = $urandom;
      ldResult   = $urandom;
      pc_current = ($urandom_range(0, 7) == 0) ? (32'hFFFFFFFC + 32'($urandom_range(0, 3))) : $urandom;
      iss_valid  = $urandom_range(0, 1);
      iss_rd     = ($urandom_range(0, 3) == 0) ? Rd : 4'($urandom_range(0, 15));
      reg_addr1  = ($urandom_range(0, 2) == 0) ? (isCall ? 4'd15 : Rd) : 4'($urandom_range(0, 15));
      reg_addr2  = ($urandom_range(0, 3) == 0) ? reg_addr1 : 4'($urandom_range(0, 15));
      check_all("rnd");
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
